gol_gen_scheduler: RTL and testbench

//   Paces the Game-of-Life engine against the 720p60 video timing. Counts frames, issues one

---
 rtl/gol_gen_scheduler_pkg.sv | 13 +
 rtl/gol_gen_scheduler_frame_divider.sv | 48 ++++
 rtl/gol_gen_scheduler.sv | 105 ++++++++++
 tb/tb_gol_gen_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_gen_scheduler_pkg.sv
// Shared scheduler definitions: FSM state encodings and debug state width.
// Imported by the scheduler top and its frame divider.
package gol_gen_scheduler_pkg;

  localparam int SCHED_STATE_W = 3;

  localparam logic [SCHED_STATE_W-1:0] S_WAIT_INIT = 3'd0;
  localparam logic [SCHED_STATE_W-1:0] S_IDLE      = 3'd1;
  localparam logic [SCHED_STATE_W-1:0] S_START     = 3'd2;
  localparam logic [SCHED_STATE_W-1:0] S_BUSY      = 3'd3;
  localparam logic [SCHED_STATE_W-1:0] S_SWAP      = 3'd4;

endpackage

// File: rtl/gol_gen_scheduler_frame_divider.sv
// Frame divider: counts SOFs while running and emits a registered 1-cycle tick every
// max(rate,1) frames; counter holds while paused and clears while the engine is uninitialised.
module gol_gen_scheduler_frame_divider #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              sof_i,
  input  logic              run_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              tick_o
);

  logic [RATE_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [RATE_W-1:0] limit;
  logic              tick_q, tick_d;

  // Compare with >= so a rate lowered below the current count ticks on the next SOF.
  always_comb begin
    limit       = (rate_i == '0) ? '0 : rate_i - 1'b1;
    frame_cnt_d = frame_cnt_q;
    tick_d      = 1'b0;
    if (clr_i) begin
      frame_cnt_d = '0;
    end else if (sof_i && run_i) begin
      if (frame_cnt_q >= limit) begin
        frame_cnt_d = '0;
        tick_d      = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      tick_q      <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/gol_gen_scheduler.sv
// Paces the GoL engine against video frames: starts one generation per tick or step,
// waits for engine_done, and swaps display/compute banks only at vblank entry.
module gol_gen_scheduler
  import gol_gen_scheduler_pkg::*;
#(
  parameter int RATE_W = 8,
  parameter int GEN_W  = 16,
  parameter int OVR_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_done,
  input  logic                     video_sof,
  input  logic                     vblank_start,
  input  logic                     run,
  input  logic                     step,
  input  logic [RATE_W-1:0]        rate,
  output logic                     engine_start,
  input  logic                     engine_done,
  output logic                     ram_select,
  output logic [GEN_W-1:0]         gen_count,
  output logic [OVR_W-1:0]         overrun_cnt,
  output logic [SCHED_STATE_W-1:0] sched_state
);

  logic                     tick;
  logic [SCHED_STATE_W-1:0] state_q, state_d;
  logic                     start_q, start_d;
  logic                     ram_sel_q, ram_sel_d;
  logic [GEN_W-1:0]         gen_q, gen_d;
  logic [OVR_W-1:0]         ovr_q, ovr_d;
  logic                     step_pend_q, step_pend_d;

  gol_gen_scheduler_frame_divider #(.RATE_W(RATE_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (~init_done),
    .sof_i  (video_sof),
    .run_i  (run),
    .rate_i (rate),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    ram_sel_d   = ram_sel_q;
    gen_d       = gen_q;
    ovr_d       = ovr_q;
    step_pend_d = step_pend_q;
    // A tick that cannot be served immediately is a missed deadline.
    if (tick && (state_q != S_IDLE) && (ovr_q != '1)) begin
      ovr_d = ovr_q + 1'b1;
    end
    if (!init_done) begin
      state_d     = S_WAIT_INIT;
      step_pend_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_INIT: state_d = S_IDLE;
        S_IDLE:      if (tick || step_pend_q) state_d = S_START;
        S_START:     state_d = S_BUSY;
        S_BUSY:      if (engine_done) state_d = S_SWAP;
        S_SWAP: begin
          if (vblank_start) begin
            state_d   = S_IDLE;
            ram_sel_d = ~ram_sel_q;
            gen_d     = gen_q + 1'b1;
          end
        end
        default:     state_d = S_WAIT_INIT;
      endcase
      if (state_d == S_START) begin
        step_pend_d = 1'b0;
      end else if (step && !run) begin
        step_pend_d = 1'b1;
      end
    end
    start_d = (state_d == S_START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT_INIT;
      start_q     <= 1'b0;
      ram_sel_q   <= 1'b0;
      gen_q       <= '0;
      ovr_q       <= '0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      ram_sel_q   <= ram_sel_d;
      gen_q       <= gen_d;
      ovr_q       <= ovr_d;
      step_pend_q <= step_pend_d;
    end
  end

  assign engine_start = start_q;
  assign ram_select   = ram_sel_q;
  assign gen_count    = gen_q;
  assign overrun_cnt  = ovr_q;
  assign sched_state  = state_q;

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Directed bench for gol_gen_scheduler using short synthetic frames, an engine responder
// and a scoreboard of expected bank swaps.
module tb_gol_gen_scheduler;
  import gol_gen_scheduler_pkg::*;

  localparam int FP = 60;
  localparam int VB = 50;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic        video_sof;
  logic        vblank_start;
  logic        run;
  logic        step;
  logic [7:0]  rate;
  logic        engine_start;
  logic        engine_done;
  logic        ram_select;
  logic [15:0] gen_count;
  logic [7:0]  overrun_cnt;
  logic [2:0]  sched_state;

  logic        done_resp;
  logic        done_man;
  logic        done_en;
  int          done_dly;
  int          n_cmp;
  int          n_bad;
  int          n_start;
  int          base;
  logic        exp_rs;
  logic [15:0] exp_gen;
  logic [16:0] sb_q[$];

  assign engine_done = done_resp | done_man;

  gol_gen_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .init_done    (init_done),
    .video_sof    (video_sof),
    .vblank_start (vblank_start),
    .run          (run),
    .step         (step),
    .rate         (rate),
    .engine_start (engine_start),
    .engine_done  (engine_done),
    .ram_select   (ram_select),
    .gen_count    (gen_count),
    .overrun_cnt  (overrun_cnt),
    .sched_state  (sched_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_swaps(input int n);
    for (int i = 0; i < n; i++) begin
      exp_rs  = ~exp_rs;
      exp_gen = exp_gen + 16'd1;
      sb_q.push_back({exp_rs, exp_gen});
    end
  endtask

  task automatic run_frames(input int n, input int step_a, input int step_b);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < FP; c++) begin
        @(posedge clk); #1;
        video_sof    = (c == 0);
        vblank_start = (c == VB);
        step         = (f == 0) && ((c == step_a) || (c == step_b));
        if ((f == 0) && (c == step_b)) check("step2_in_busy", sched_state, S_BUSY);
      end
    end
    @(posedge clk); #1;
    video_sof    = 1'b0;
    vblank_start = 1'b0;
    step         = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int k;
    k = 0;
    while ((sched_state !== s) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check("wait_state", sched_state, s);
  endtask

  // Engine model: answers each engine_start with engine_done after done_dly cycles.
  initial begin
    done_resp = 1'b0;
    forever begin
      @(negedge clk);
      if ((engine_start === 1'b1) && done_en) begin
        repeat (done_dly) @(posedge clk);
        #1 done_resp = 1'b1;
        @(posedge clk);
        #1 done_resp = 1'b0;
      end
    end
  end

  initial begin
    n_start = 0;
    forever begin
      @(negedge clk);
      if (engine_start === 1'b1) n_start++;
    end
  end

  // Every bank flip must be expected, carry the expected gen_count and follow vblank_start.
  initial begin
    logic        rs_prev;
    logic        vb_prev;
    logic [16:0] e;
    rs_prev = 1'b0;
    vb_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        vb_prev = 1'b0;
      end else if (ram_select !== rs_prev) begin
        check("swap_expected", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("swap_ram_select", ram_select, e[16]);
          check("swap_gen_count", gen_count, e[15:0]);
          check("swap_at_vblank", vb_prev, 1);
        end
      end
      rs_prev = ram_select;
      vb_prev = vblank_start;
    end
  end

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    exp_rs       = 1'b0;
    exp_gen      = 16'd0;
    rst          = 1'b1;
    init_done    = 1'b0;
    video_sof    = 1'b0;
    vblank_start = 1'b0;
    run          = 1'b0;
    step         = 1'b0;
    rate         = 8'd1;
    done_man     = 1'b0;
    done_en      = 1'b1;
    done_dly     = 100;

    #1;
    check("rst_state", sched_state, S_WAIT_INIT);
    check("rst_engine_start", engine_start, 0);
    check("rst_ram_select", ram_select, 0);
    check("rst_gen_count", gen_count, 0);
    check("rst_overrun", overrun_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frames(1, -1, -1);
    check("hold_wait_init", sched_state, S_WAIT_INIT);
    init_done = 1'b1;
    wait_state(S_IDLE, 4);

    // T2: free-run at rate 4, engine takes 100 cycles
    base = n_start;
    run  = 1'b1;
    rate = 8'd4;
    expect_swaps(3);
    run_frames(13, -1, -1);
    check("t2_starts", n_start - base, 3);
    check("t2_gen_count", gen_count, 3);
    check("t2_swaps_done", sb_q.size(), 0);

    // T3: rate 0 acts as rate 1, then a 4->2 change ticks on the next SOF
    base     = n_start;
    done_dly = 10;
    rate     = 8'd0;
    expect_swaps(4);
    run_frames(4, -1, -1);
    check("t3_rate0_starts", n_start - base, 4);
    base = n_start;
    rate = 8'd4;
    run_frames(1, -1, -1);
    check("t3_rate4_nostart", n_start - base, 0);
    rate = 8'd2;
    expect_swaps(1);
    run_frames(1, -1, -1);
    check("t3_rate2_start", n_start - base, 1);
    check("t3_swaps_done", sb_q.size(), 0);

    // T4: single-step while paused, a second step latched during BUSY, step ignored in run
    run  = 1'b0;
    base = n_start;
    expect_swaps(1);
    run_frames(2, 0, -1);
    check("t4_single_step", n_start - base, 1);
    base     = n_start;
    done_dly = 100;
    expect_swaps(2);
    run_frames(4, 0, 20);
    check("t4_latched_step", n_start - base, 2);
    check("t4_swaps_done", sb_q.size(), 0);
    base = n_start;
    run  = 1'b1;
    rate = 8'd255;
    run_frames(2, 0, -1);
    check("t4_step_in_run", n_start - base, 0);
    run = 1'b0;
    check("t4_gen_count", gen_count, exp_gen);

    // T5: engine stalls at rate 1, overruns accumulate and saturate
    base    = n_start;
    done_en = 1'b0;
    rate    = 8'd1;
    run     = 1'b1;
    run_frames(4, -1, -1);
    check("t5_overrun3", overrun_cnt, 3);
    check("t5_one_start", n_start - base, 1);
    run_frames(257, -1, -1);
    check("t5_overrun_sat", overrun_cnt, 8'hFF);
    check("t5_no_extra_start", n_start - base, 1);
    run = 1'b0;
    @(posedge clk); #1 done_man = 1'b1;
    @(posedge clk); #1 done_man = 1'b0;
    wait_state(S_SWAP, 4);

    // T6: init_done drop while a swap is pending discards it
    init_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_state_wait_init", sched_state, S_WAIT_INIT);
    run_frames(1, -1, -1);
    check("t6_ram_select_hold", ram_select, exp_rs);
    check("t6_gen_hold", gen_count, exp_gen);
    check("t6_overrun_hold", overrun_cnt, 8'hFF);
    init_done = 1'b1;
    wait_state(S_IDLE, 4);
    base     = n_start;
    done_en  = 1'b1;
    done_dly = 10;
    run      = 1'b1;
    expect_swaps(2);
    run_frames(2, -1, -1);
    check("t6_restart_starts", n_start - base, 2);
    check("t6_swaps_done", sb_q.size(), 0);

    // T1: asynchronous reset while the engine is busy
    done_en = 1'b0;
    run_frames(1, -1, -1);
    check("t1_in_busy", sched_state, S_BUSY);
    @(posedge clk); #1 rst = 1'b1;
    #2;
    check("t1_state", sched_state, S_WAIT_INIT);
    check("t1_engine_start", engine_start, 0);
    check("t1_ram_select", ram_select, 0);
    check("t1_gen_count", gen_count, 0);
    check("t1_overrun", overrun_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
